// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port handshaked memory between
// instruction fetch and the data (load/store) path. One transaction is
// outstanding at a time; data has priority, fetch responses may be flushed.
// Optional build macro MEM_ARB_STARVE_GUARD_EN enables the fetch starvation
// guard; without it data has strict priority.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // fetch request / response
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_req_ready,
   input  logic              if_flush,
   output logic              if_resp_valid,
   output logic [DATA_W-1:0] if_resp_data,
   // data request / response
   input  logic              d_req_valid,
   input  logic              d_req_we,
   input  logic [2:0]        d_req_mode,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_req_ready,
   output logic              d_resp_valid,
   output logic [DATA_W-1:0] d_resp_data,
   // memory side
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [2:0]        mem_mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t              state_q;
   logic                owner_is_d_q;   // 1 = data owns the transaction
   logic                drop_q;         // fetch response must be discarded
   logic                we_q;
   logic [2:0]          mode_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                if_resp_valid_q;
   logic [DATA_W-1:0]   if_resp_data_q;
   logic                d_resp_valid_q;
   logic [DATA_W-1:0]   d_resp_data_q;

   logic                force_f;
   logic                is_idle;
   logic                grant_d;
   logic                grant_f;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [3:0]          starve_q;

   assign force_f = (starve_q == 4'(STARVE_MAX)) && if_req_valid && d_req_valid;

   // Count data grants taken while fetch waits; a fetch grant clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= 4'd0;
      end else if (grant_f) begin
         starve_q <= 4'd0;
      end else if (grant_d && if_req_valid && (starve_q != 4'(STARVE_MAX))) begin
         starve_q <= starve_q + 4'd1;
      end
   end
`else
   assign force_f = 1'b0;
`endif

   // Readies are gated by reset so every output is low while rst_n is held.
   assign is_idle = rst_n && (state_q == IDLE);
   assign grant_d = is_idle && d_req_valid && !force_f;
   assign grant_f = is_idle && if_req_valid && !grant_d;

   assign if_req_ready  = grant_f;
   assign d_req_ready   = grant_d;
   assign mem_req_valid = (state_q == ISSUE);
   assign mem_we        = we_q;
   assign mem_mode      = mode_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign if_resp_valid = if_resp_valid_q;
   assign if_resp_data  = if_resp_data_q;
   assign d_resp_valid  = d_resp_valid_q;
   assign d_resp_data   = d_resp_data_q;

   // Transaction FSM: grant and latch, hold request until accepted, route response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         owner_is_d_q    <= 1'b0;
         drop_q          <= 1'b0;
         we_q            <= 1'b0;
         mode_q          <= 3'b000;
         addr_q          <= '0;
         wdata_q         <= '0;
         if_resp_valid_q <= 1'b0;
         if_resp_data_q  <= '0;
         d_resp_valid_q  <= 1'b0;
         d_resp_data_q   <= '0;
      end else begin
         if_resp_valid_q <= 1'b0;
         d_resp_valid_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  state_q      <= ISSUE;
                  owner_is_d_q <= 1'b1;
                  drop_q       <= 1'b0;
                  we_q         <= d_req_we;
                  mode_q       <= d_req_mode;
                  addr_q       <= d_req_addr;
                  wdata_q      <= d_req_wdata;
               end else if (grant_f) begin
                  state_q      <= ISSUE;
                  owner_is_d_q <= 1'b0;
                  drop_q       <= if_flush;
                  we_q         <= 1'b0;
                  mode_q       <= 3'b010;
                  addr_q       <= if_req_addr;
                  wdata_q      <= '0;
               end
            end
            ISSUE: begin
               if (!owner_is_d_q && if_flush) begin
                  drop_q <= 1'b1;
               end
               if (mem_req_ready) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (!owner_is_d_q && if_flush) begin
                  drop_q <= 1'b1;
               end
               if (mem_resp_valid) begin
                  state_q <= IDLE;
                  if (owner_is_d_q) begin
                     d_resp_valid_q <= 1'b1;
                     d_resp_data_q  <= we_q ? '0 : mem_resp_data;
                  end else if (!drop_q && !if_flush) begin
                     // a flush arriving with the response still kills it
                     if_resp_valid_q <= 1'b1;
                     if_resp_data_q  <= mem_resp_data;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset, table of single
// transactions, contention grant order, reset mid-transaction and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        if_req_valid;
   logic [31:0] if_req_addr;
   logic        if_req_ready;
   logic        if_flush;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        d_req_valid;
   logic        d_req_we;
   logic [2:0]  d_req_mode;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic        d_req_ready;
   logic        d_resp_valid;
   logic [31:0] d_resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_we;
   logic [2:0]  mem_mode;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_mode(d_req_mode),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1);
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   bit          m_busy, m_issued, m_fetch, m_drop;
   logic        m_we;
   logic [2:0]  m_mode;
   logic [31:0] m_addr, m_wdata;
   int          m_starve;
   bit          e_ifv, e_dv;
   logic [31:0] e_ifd, e_dd;

   task automatic model_reset();
      m_busy = 0; m_issued = 0; m_fetch = 0; m_drop = 0;
      m_we = 0; m_mode = 3'b000; m_addr = 0; m_wdata = 0;
      m_starve = 0;
      e_ifv = 0; e_dv = 0; e_ifd = 0; e_dd = 0;
   endtask

   task automatic exp_ready(output bit ef, output bit ed);
      bit force_f;
      ef = 0;
      ed = 0;
      force_f = GUARD && (m_starve >= STARVE_MAX) && if_req_valid && d_req_valid;
      if (rst_n && !m_busy) begin
         if (d_req_valid && !force_f) ed = 1;
         else if (if_req_valid) ef = 1;
      end
   endtask

   task automatic model_update();
      bit ef, ed;
      if (!rst_n) begin
         model_reset();
         return;
      end
      exp_ready(ef, ed);
      e_ifv = 0;
      e_dv  = 0;
      if (m_busy) begin
         if (m_fetch && if_flush) m_drop = 1;
         if (m_issued && mem_resp_valid) begin
            if (m_fetch) begin
               if (!m_drop) begin e_ifv = 1; e_ifd = mem_resp_data; end
            end else begin
               e_dv = 1;
               e_dd = m_we ? 32'h0 : mem_resp_data;
            end
            m_busy = 0;
         end else if (!m_issued && mem_req_ready) begin
            m_issued = 1;
         end
      end else if (ef || ed) begin
         m_busy = 1; m_issued = 0; m_fetch = ef;
         m_drop = ef && if_flush;
         m_we    = ed ? d_req_we : 1'b0;
         m_mode  = ed ? d_req_mode : 3'b010;
         m_addr  = ed ? d_req_addr : if_req_addr;
         m_wdata = ed ? d_req_wdata : 32'h0;
         if (ef) m_starve = 0;
         else if (if_req_valid && m_starve < STARVE_MAX) m_starve++;
      end
   endtask

   // snapshot of DUT outputs taken in the current cycle
   logic        s_ifr, s_dr, s_mv, s_ifv, s_dv, s_we;
   logic [2:0]  s_mode;
   logic [31:0] s_ifd, s_dd, s_addr, s_wdata;

   // inputs are driven at negedge; sample 1ns later, then advance one clock
   task automatic tick();
      bit ef, ed;
      #1;
      if (!rst_n) model_reset();
      exp_ready(ef, ed);
      chk("if_req_ready", if_req_ready, ef);
      chk("d_req_ready", d_req_ready, ed);
      chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
      chk("mem_we", mem_we, m_we);
      chk("mem_mode", mem_mode, m_mode);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_resp_valid", if_resp_valid, e_ifv);
      chk("d_resp_valid", d_resp_valid, e_dv);
      if (e_ifv) chk("if_resp_data", if_resp_data, e_ifd);
      if (e_dv)  chk("d_resp_data", d_resp_data, e_dd);
      s_ifr = if_req_ready; s_dr = d_req_ready; s_mv = mem_req_valid;
      s_ifv = if_resp_valid; s_dv = d_resp_valid; s_we = mem_we;
      s_mode = mem_mode; s_ifd = if_resp_data; s_dd = d_resp_data;
      s_addr = mem_addr; s_wdata = mem_wdata;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      if_req_valid = 0; if_req_addr = 0; if_flush = 0;
      d_req_valid = 0; d_req_we = 0; d_req_mode = 0; d_req_addr = 0; d_req_wdata = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && m_busy; i++) begin
         if_req_valid = 0; d_req_valid = 0; if_flush = 0;
         mem_req_ready = 1;
         mem_resp_valid = m_busy && m_issued;
         mem_resp_data = $urandom;
         tick();
      end
      if (m_busy) chk("drain_timeout", m_busy, 0);
      idle_inputs();
      tick();
   endtask

   // ---------------- single-transaction vector table ----------------
   typedef struct {
      bit          fetch;
      bit          we;
      logic [2:0]  mode;
      logic [31:0] addr, wdata, rdata;
      int          rdly, wdly;
      int          flush_at;  // 0 none, 1 WAIT, 2 with response, 3 at accept, 4 in ISSUE
      bit          e_we;
      logic [2:0]  e_mode;
      logic [31:0] e_wdata;
      bit          e_ifv, e_dv;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs[9];
   int   grants[$];

   initial begin
      // fetch fields: we, mode, wdata are forced regardless of d_req_* wires
      vecs[0] = '{0,0,3'b010,32'h40, 32'h0,       32'hDEADBEEF,0,0,0, 0,3'b010,32'h0,       0,1,32'hDEADBEEF};
      vecs[1] = '{0,1,3'b000,32'h80, 32'h12345678,32'hCAFEF00D,0,0,0, 1,3'b000,32'h12345678,0,1,32'h0};
      vecs[2] = '{0,0,3'b100,32'h44, 32'h0,       32'h000000A5,5,2,0, 0,3'b100,32'h0,       0,1,32'h000000A5};
      vecs[3] = '{1,1,3'b111,32'h100,32'hFFFFFFFF,32'h00000013,0,2,1, 0,3'b010,32'h0,       0,0,32'h0};
      vecs[4] = '{1,1,3'b001,32'h104,32'hFFFFFFFF,32'h00100093,1,1,0, 0,3'b010,32'h0,       1,0,32'h00100093};
      vecs[5] = '{1,0,3'b000,32'h108,32'h0,       32'h00000013,0,0,2, 0,3'b010,32'h0,       0,0,32'h0};
      vecs[6] = '{1,0,3'b000,32'h10C,32'h0,       32'h00000013,0,0,3, 0,3'b010,32'h0,       0,0,32'h0};
      vecs[7] = '{1,0,3'b000,32'h110,32'h0,       32'h00000013,2,0,4, 0,3'b010,32'h0,       0,0,32'h0};
      vecs[8] = '{0,1,3'b001,32'h84, 32'hA5A5_5A5A,32'h77777777,3,1,0, 1,3'b001,32'hA5A5_5A5A,0,1,32'h0};

      model_reset();
      idle_inputs();
      rst_n = 0;
      @(negedge clk);

      // reset held with every input active: all outputs must stay 0
      if_req_valid = 1; if_req_addr = 32'h200; if_flush = 1;
      d_req_valid = 1; d_req_we = 1; d_req_mode = 3'b111; d_req_addr = 32'h300;
      d_req_wdata = 32'h55AA55AA; mem_req_ready = 1; mem_resp_valid = 1;
      mem_resp_data = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_outputs", {s_ifr, s_dr, s_mv, s_ifv, s_dv, s_we}, 6'h0);
         chk("rst_fields", {s_mode, s_addr, s_wdata, s_ifd, s_dd}, 131'h0);
      end
      // release: first IDLE cycle grants data
      rst_n = 1; if_flush = 0; mem_resp_valid = 0; mem_req_ready = 0;
      tick();
      chk("rst_first_grant", {s_ifr, s_dr}, 2'b01);
      drain();

      // table of single transactions
      for (int v = 0; v < 9; v++) begin
         idle_inputs();
         tick();
         if (vecs[v].fetch) begin
            if_req_valid = 1; if_req_addr = vecs[v].addr; d_req_addr = ~vecs[v].addr;
         end else begin
            d_req_valid = 1; d_req_addr = vecs[v].addr;
         end
         d_req_we = vecs[v].we; d_req_mode = vecs[v].mode; d_req_wdata = vecs[v].wdata;
         if_flush = (vecs[v].flush_at == 3);
         tick();
         chk("tbl_accept", vecs[v].fetch ? s_ifr : s_dr, 1);
         if_flush = 0;
         // other requesters stay active while busy: neither may be accepted
         if_req_valid = 1; d_req_valid = 1;
         for (int i = 0; i < vecs[v].rdly; i++) begin
            if_flush = (vecs[v].flush_at == 4) && (i == 0);
            tick();
            chk("tbl_stall_valid", s_mv, 1);
            chk("tbl_stall_fields", {s_we, s_mode, s_addr, s_wdata},
                {vecs[v].e_we, vecs[v].e_mode, vecs[v].addr, vecs[v].e_wdata});
            chk("tbl_stall_ready", {s_ifr, s_dr}, 2'b00);
         end
         if_flush = 0;
         mem_req_ready = 1;
         tick();
         chk("tbl_issue_valid", s_mv, 1);
         chk("tbl_issue_fields", {s_we, s_mode, s_addr, s_wdata},
             {vecs[v].e_we, vecs[v].e_mode, vecs[v].addr, vecs[v].e_wdata});
         mem_req_ready = 0;
         for (int i = 0; i < vecs[v].wdly; i++) begin
            if_flush = (vecs[v].flush_at == 1) && (i == 0);
            tick();
            chk("tbl_wait_valid", s_mv, 0);
            chk("tbl_wait_ready", {s_ifr, s_dr}, 2'b00);
         end
         if_req_valid = 0; d_req_valid = 0;
         mem_resp_valid = 1; mem_resp_data = vecs[v].rdata;
         if_flush = (vecs[v].flush_at == 2);
         tick();
         chk("tbl_resp_early", {s_ifv, s_dv}, 2'b00);
         mem_resp_valid = 0; if_flush = 0; mem_resp_data = $urandom;
         tick();
         $display("vec %0d: fetch=%0b addr=0x%0h if_resp=%0b d_resp=%0b", v,
                  vecs[v].fetch, vecs[v].addr, s_ifv, s_dv);
         chk("tbl_if_resp_valid", s_ifv, vecs[v].e_ifv);
         chk("tbl_d_resp_valid", s_dv, vecs[v].e_dv);
         if (vecs[v].e_ifv) chk("tbl_if_resp_data", s_ifd, vecs[v].e_data);
         if (vecs[v].e_dv)  chk("tbl_d_resp_data", s_dd, vecs[v].e_data);
         tick();
         chk("tbl_pulse_width", {s_ifv, s_dv}, 2'b00);
      end

      // contention: both requesters held, counter cleared by reset
      idle_inputs();
      rst_n = 0;
      tick();
      rst_n = 1;
      grants.delete();
      for (int i = 0; i < 200 && grants.size() < 12; i++) begin
         if_req_valid = 1; if_req_addr = 32'h1000 + 32'(i * 4);
         d_req_valid = 1; d_req_addr = 32'h2000 + 32'(i * 4); d_req_we = 0; d_req_mode = 3'b010;
         mem_req_ready = 1;
         mem_resp_valid = m_busy && m_issued;
         mem_resp_data = $urandom;
         tick();
         if (s_ifr) grants.push_back(0);
         if (s_dr)  grants.push_back(1);
      end
      chk("contention_grant_count", grants.size(), 12);
      for (int k = 0; k < grants.size(); k++) begin
         $display("grant %0d: %s", k, grants[k] ? "D" : "F");
         chk("contention_order", grants[k], (GUARD && (k % 5 == 4)) ? 0 : 1);
      end
      drain();

      // reset in the middle of a load, then a late memory response
      d_req_valid = 1; d_req_addr = 32'h400; d_req_mode = 3'b010;
      tick();
      d_req_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      tick();
      rst_n = 0;
      tick();
      chk("midrst_outputs", {s_ifr, s_dr, s_mv, s_ifv, s_dv, s_we}, 6'h0);
      chk("midrst_addr", s_addr, 0);
      rst_n = 1;
      mem_resp_valid = 1; mem_resp_data = 32'hBAD0BAD0;
      tick();
      mem_resp_valid = 0;
      tick();
      chk("midrst_late_resp", {s_ifv, s_dv}, 2'b00);
      $display("midrst: late response d_resp=%0b if_resp=%0b", s_dv, s_ifv);

      // randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         if_req_valid = ($urandom_range(0, 99) < 60);
         if_req_addr = {$urandom_range(0, 65535), 2'b00};
         d_req_valid = ($urandom_range(0, 99) < 60);
         d_req_we = $urandom_range(0, 1);
         d_req_mode = 3'($urandom_range(0, 7));
         d_req_addr = $urandom;
         d_req_wdata = $urandom;
         if_flush = ($urandom_range(0, 99) < 8);
         mem_req_ready = ($urandom_range(0, 99) < 50);
         if (m_busy && m_issued) mem_resp_valid = ($urandom_range(0, 99) < 50);
         else mem_resp_valid = !m_busy && ($urandom_range(0, 99) < 5);
         mem_resp_data = $urandom;
         tick();
         if (s_ifv || s_dv)
            $display("rnd %0d: if_resp=%0b 0x%0h d_resp=%0b 0x%0h", i, s_ifv, s_ifd, s_dv, s_dd);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
